// File: rtl/regfile_bist_if.sv
// rtl/regfile_bist_if.sv - register-file write/read port bundle between the BIST and the register file
interface regfile_bist_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  write;
  logic [ADDR_WIDTH-1:0] write_sel;
  logic [DATA_WIDTH-1:0] write_data;
  logic [ADDR_WIDTH-1:0] read_sel1;
  logic [ADDR_WIDTH-1:0] read_sel2;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;

  modport master (
    output write, write_sel, write_data, read_sel1, read_sel2,
    input  read_data1, read_data2
  );

  modport slave (
    input  write, write_sel, write_data, read_sel1, read_sel2,
    output read_data1, read_data2
  );
endinterface

// File: rtl/regfile_bist.sv
// rtl/regfile_bist.sv - register-file BIST: two complementary pattern passes, dual-port readback
module regfile_bist #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 5,
  parameter bit ZERO_REG_HARDWIRED = 1'b1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [ADDR_WIDTH+1:0] o_fail_count,
  output logic [ADDR_WIDTH-1:0] o_first_fail_sel,
  regfile_bist_if.master        rf
);

  localparam int FW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                r_state;
  logic                  r_phase;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_first_seen;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic [FW-1:0]         r_fail_count;
  logic [ADDR_WIDTH-1:0] r_first_fail_sel;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_write_sel;
  logic [DATA_WIDTH-1:0] r_write_data;
  logic [ADDR_WIDTH-1:0] r_read_sel;

  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_expected;
  logic                  w_miss1;
  logic                  w_miss2;
  logic [1:0]            w_inc;
  logic [FW:0]           w_sum;
  logic [FW-1:0]         w_fail_next;

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a, input logic p);
    logic [DATA_WIDTH-1:0] base;
    base = DATA_WIDTH'(32'h5A5A_5A00) ^ DATA_WIDTH'(a);
    return p ? ~base : base;
  endfunction

  assign w_addr_next = r_addr + 1'b1;

  // Register 0 of a hardwired file always reads zero, though the pattern is still written to it.
  assign w_expected  = (ZERO_REG_HARDWIRED && (r_addr == '0)) ? '0 : pattern(r_addr, r_phase);
  assign w_miss1     = (rf.read_data1 != w_expected);
  assign w_miss2     = (rf.read_data2 != w_expected);
  assign w_inc       = {1'b0, w_miss1} + {1'b0, w_miss2};
  assign w_sum       = {1'b0, r_fail_count} + (FW+1)'(w_inc);
  assign w_fail_next = w_sum[FW] ? '1 : w_sum[FW-1:0];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state          <= S_IDLE;
      r_phase          <= 1'b0;
      r_addr           <= '0;
      r_first_seen     <= 1'b0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail_count     <= '0;
      r_first_fail_sel <= '0;
      r_write          <= 1'b0;
      r_write_sel      <= '0;
      r_write_data     <= '0;
      r_read_sel       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state          <= S_WRITE;
            r_phase          <= 1'b0;
            r_addr           <= '0;
            r_first_seen     <= 1'b0;
            r_busy           <= 1'b1;
            r_done           <= 1'b0;
            r_pass           <= 1'b0;
            r_fail_count     <= '0;
            r_first_fail_sel <= '0;
            r_write          <= 1'b1;
            r_write_sel      <= '0;
            r_write_data     <= pattern('0, 1'b0);
          end
        end
        S_WRITE: begin
          if (r_addr == ADDR_MAX) begin
            r_state      <= S_READ;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_write_sel  <= '0;
            r_write_data <= '0;
            r_read_sel   <= '0;
          end else begin
            r_addr       <= w_addr_next;
            r_write_sel  <= w_addr_next;
            r_write_data <= pattern(w_addr_next, r_phase);
          end
        end
        S_READ: begin
          r_fail_count <= w_fail_next;
          if ((w_inc != 2'd0) && !r_first_seen) begin
            r_first_seen     <= 1'b1;
            r_first_fail_sel <= r_addr;
          end
          if (r_addr == ADDR_MAX) begin
            r_addr     <= '0;
            r_read_sel <= '0;
            if (!r_phase) begin
              r_state      <= S_WRITE;
              r_phase      <= 1'b1;
              r_write      <= 1'b1;
              r_write_sel  <= '0;
              r_write_data <= pattern('0, 1'b1);
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (w_fail_next == '0);
            end
          end else begin
            r_addr     <= w_addr_next;
            r_read_sel <= w_addr_next;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_pass           = r_pass;
  assign o_fail_count     = r_fail_count;
  assign o_first_fail_sel = r_first_fail_sel;
  assign rf.write         = r_write;
  assign rf.write_sel     = r_write_sel;
  assign rf.write_data    = r_write_data;
  assign rf.read_sel1     = r_read_sel;
  assign rf.read_sel2     = r_read_sel;

endmodule

// File: tb/tb_regfile_bist.sv
// tb/tb_regfile_bist.sv - directed bench: fault-free, stuck-at, zero-reg, saturation, reset and start-while-busy runs
module tb_regfile_bist;
  logic clk;
  logic reset;
  logic start;
  int   mode;
  int   en;
  int   total;
  int   bad;

  logic       busy_a, done_a, pass_a;
  logic [6:0] fail_a;
  logic [4:0] ffs_a;
  logic       busy_b, done_b, pass_b;
  logic [6:0] fail_b;
  logic [4:0] ffs_b;

  logic [31:0] mem_a [32];
  logic [31:0] mem_b [32];

  regfile_bist_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifa ();
  regfile_bist_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) ifb ();

  regfile_bist #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_HARDWIRED(1'b1)) dut (
    .i_clock(clk), .i_reset(reset), .i_start(start),
    .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
    .o_fail_count(fail_a), .o_first_fail_sel(ffs_a), .rf(ifa)
  );

  regfile_bist #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG_HARDWIRED(1'b0)) dut_nz (
    .i_clock(clk), .i_reset(reset), .i_start(start),
    .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
    .o_fail_count(fail_b), .o_first_fail_sel(ffs_b), .rf(ifb)
  );

  // mode 0: good file, reg0 hardwired; 1: reg5 bit3 stuck-at-0; 2: reg0 stores data; 3: reads all ones
  function automatic logic [31:0] model_rd(input logic [31:0] v, input logic [4:0] sel, input int m);
    if (m == 3) return 32'hFFFF_FFFF;
    if ((m == 0 || m == 1) && sel == 5'd0) return 32'h0;
    if (m == 1 && sel == 5'd5) return v & ~32'h8;
    return v;
  endfunction

  assign ifa.read_data1 = model_rd(mem_a[ifa.read_sel1], ifa.read_sel1, mode);
  assign ifa.read_data2 = model_rd(mem_a[ifa.read_sel2], ifa.read_sel2, mode);
  assign ifb.read_data1 = model_rd(mem_b[ifb.read_sel1], ifb.read_sel1, mode);
  assign ifb.read_data2 = model_rd(mem_b[ifb.read_sel2], ifb.read_sel2, mode);

  always @(posedge clk) begin
    if (ifa.write) mem_a[ifa.write_sel] <= ifa.write_data;
    if (ifb.write) mem_b[ifb.write_sel] <= ifb.write_data;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    en = 0;
    #1;
    start = 1'b0;
  endtask

  task automatic adv_to(input int t);
    while (en < t) begin
      @(posedge clk);
      en++;
    end
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    en    = 0;
    mode  = 0;
    start = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_pass", 64'(pass_a), 64'd0);
    chk("rst_write", 64'(ifa.write), 64'd0);
    chk("rst_fail", 64'(fail_a), 64'd0);
    chk("rst_ffs", 64'(ffs_a), 64'd0);
    chk("rst_wsel", 64'(ifa.write_sel), 64'd0);
    chk("rst_wdata", 64'(ifa.write_data), 64'd0);
    chk("rst_rsel1", 64'(ifa.read_sel1), 64'd0);
    chk("rst_rsel2", 64'(ifa.read_sel2), 64'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Fault-free run with write-trace checks
    do_start();
    chk("ff_busy_e0", 64'(busy_a), 64'd1);
    adv_to(3);
    chk("ff_wsel_e3", 64'(ifa.write_sel), 64'd3);
    chk("ff_wdata_e3", 64'(ifa.write_data), 64'h5A5A5A03);
    adv_to(4);
    chk("ff_mem3_e4", 64'(mem_a[3]), 64'h5A5A5A03);
    adv_to(67);
    chk("ff_mem3_e67", 64'(mem_a[3]), 64'h5A5A5A03);
    chk("ff_wdata_e67", 64'(ifa.write_data), 64'hA5A5A5FC);
    adv_to(68);
    chk("ff_mem3_e68", 64'(mem_a[3]), 64'hA5A5A5FC);
    adv_to(127);
    chk("ff_busy_e127", 64'(busy_a), 64'd1);
    chk("ff_done_e127", 64'(done_a), 64'd0);
    adv_to(128);
    chk("ff_done", 64'(done_a), 64'd1);
    chk("ff_busy", 64'(busy_a), 64'd0);
    chk("ff_pass", 64'(pass_a), 64'd1);
    chk("ff_fail", 64'(fail_a), 64'd0);
    chk("ff_ffs", 64'(ffs_a), 64'd0);

    // Stuck-at reg5 bit3, restarted from DONE
    mode = 1;
    do_start();
    chk("sa_done_cleared", 64'(done_a), 64'd0);
    chk("sa_pass_cleared", 64'(pass_a), 64'd0);
    chk("sa_busy", 64'(busy_a), 64'd1);
    adv_to(128);
    chk("sa_done", 64'(done_a), 64'd1);
    chk("sa_fail", 64'(fail_a), 64'd2);
    chk("sa_ffs", 64'(ffs_a), 64'd5);
    chk("sa_pass", 64'(pass_a), 64'd0);

    // Reg0 not hardwired in the model
    mode = 2;
    do_start();
    adv_to(128);
    chk("z_fail", 64'(fail_a), 64'd4);
    chk("z_ffs", 64'(ffs_a), 64'd0);
    chk("z_pass", 64'(pass_a), 64'd0);
    chk("z_nz_pass", 64'(pass_b), 64'd1);
    chk("z_nz_fail", 64'(fail_b), 64'd0);

    // Saturation: every read mismatches
    mode = 3;
    do_start();
    adv_to(128);
    chk("sat_fail", 64'(fail_b), 64'd127);
    chk("sat_pass", 64'(pass_b), 64'd0);
    chk("sat_ffs", 64'(ffs_b), 64'd0);

    // Reset mid-test, then a clean rerun
    mode = 2;
    do_start();
    adv_to(39);
    chk("mr_fail_pre", 64'(fail_a), 64'd2);
    reset = 1'b1;
    adv_to(40);
    reset = 1'b0;
    chk("mr_busy", 64'(busy_a), 64'd0);
    chk("mr_write", 64'(ifa.write), 64'd0);
    chk("mr_fail", 64'(fail_a), 64'd0);
    chk("mr_done", 64'(done_a), 64'd0);
    mode = 0;
    do_start();
    adv_to(128);
    chk("mr_rerun_done", 64'(done_a), 64'd1);
    chk("mr_rerun_pass", 64'(pass_a), 64'd1);

    // Start pulses while busy are ignored
    do_start();
    adv_to(9);
    start = 1'b1;
    adv_to(10);
    start = 1'b0;
    adv_to(69);
    start = 1'b1;
    adv_to(70);
    start = 1'b0;
    adv_to(127);
    chk("sb_done_e127", 64'(done_a), 64'd0);
    chk("sb_busy_e127", 64'(busy_a), 64'd1);
    adv_to(128);
    chk("sb_done", 64'(done_a), 64'd1);
    chk("sb_busy", 64'(busy_a), 64'd0);
    chk("sb_pass", 64'(pass_a), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/regfile_bist.md
# regfile_bist

Built-in self-test sequencer for the CPU register file. It is the initiator on the register file's write/read ports. On `start` it writes two complementary data patterns to every register and reads each back on both read ports, comparing against expected values. It reports `pass`, a saturating mismatch count and the first failing register index. It sits beside `registerFile` and is muxed onto that block's ports during power-on test.

## Interface
- `DATA_WIDTH`, 32, register width
- `ADDR_WIDTH`, 5, register index width (2^ADDR_WIDTH registers)
- `ZERO_REG_HARDWIRED`, 1, register 0 is expected to read 0 regardless of writes
- `clock`  in  1  single clock; all state updates on posedge
- `reset`  in  1  synchronous, active-high
- `start`  in  1  begin test; sampled only in IDLE or DONE
- `busy`  out  1  high in WRITE/READ states
- `done`  out  1  high in DONE; held until next accepted `start` or `reset`
- `pass`  out  1  valid while `done`; 1 iff `fail_count`==0
- `fail_count`  out  ADDR_WIDTH+2  saturating count of per-port mismatches
- `first_fail_sel`  out  ADDR_WIDTH  index of first mismatch; 0 if none
- `write`  out  1  register-file write enable
- `write_sel`  out  ADDR_WIDTH  write index
- `write_data`  out  DATA_WIDTH  write data
- `read_sel1`, `read_sel2`  out  ADDR_WIDTH  read indices
- `read_data1`, `read_data2`  in  DATA_WIDTH  combinational read data from the register file

## Operation
- States: IDLE, WRITE, READ, DONE. A 1-bit `phase` (0, 1) and an ADDR_WIDTH-bit `addr` counter.
- IDLE/DONE + `start`:
  - Next state WRITE, `phase`=0, `addr`=0.
  - `fail_count`, `first_fail_sel` and the first-fail flag are cleared.
  - `done`/`pass` drop.
- Expected data:
  - E(a,0) = 32'h5A5A_5A00 ^ zero-extended a.
  - E(a,1) = ~E(a,0).
  - If `ZERO_REG_HARDWIRED`, E(0,p)=0 for comparison only; written data is still the pattern.
- WRITE:
  - `write`=1, `write_sel`=`addr`, `write_data`=E(addr,phase) (unmasked pattern).
  - `addr` increments each cycle. At `addr`=max, go to READ with `addr`=0 (wrap).
- READ:
  - `read_sel1`=`read_sel2`=`addr`, `write`=0.
  - Each cycle, compare `read_data1` and `read_data2` against expected. Add 0, 1 or 2 to `fail_count`, saturating at all-ones.
  - On the first mismatch of the run, latch `addr` into `first_fail_sel`.
  - At `addr`=max: if `phase`=0, go to WRITE with `phase`=1; else go to DONE.
- Outside WRITE: `write`=0, `write_sel`=0, `write_data`=0. Outside READ: read sels=0.
- `start` while `busy` is ignored.
- `reset` at any time, including mid-test:
  - Next state IDLE.
  - All outputs 0, with `write` low from that edge on.
  - Register-file contents are left as partially written.

## Timing
- Reset values: `busy`=`done`=`pass`=`write`=0; `fail_count`=`first_fail_sel`=0; all sel/data outputs 0.
- Let E0 be the edge that samples `start`. With 32 registers:
  - Edges E1..E32 commit phase-0 writes to registers 0..31.
  - Edges E33..E64 register phase-0 comparisons.
  - E65..E96 commit phase-1 writes.
  - E97..E128 register phase-1 comparisons.
- After E128: `done`=1, `busy`=0, final `fail_count`/`pass` valid.
- Latency from start edge to `done` is 2^(ADDR_WIDTH+2) cycles.
- All outputs are registered (flop outputs). Read data is compared in the same cycle the sel is driven, so the register file must have combinational read.

## Test plan
- **Fault-free:** correct register file with register 0 hardwired, default params, pulse `start`.
  - Response: `busy` for 128 cycles, then `done`=1, `pass`=1, `fail_count`=0, `first_fail_sel`=0.
  - Check the write trace: at E4, reg 3 ← 32'h5A5A5A03. At E68, reg 3 ← 32'hA5A5A5FC.
- **Stuck-at fault:** model with reg 5 bit 3 stuck at 0.
  - Phase 0 matches (0x5A5A5A05). Phase 1 mismatches both ports (0xA5A5A5FA).
  - Response: `fail_count`=2, `first_fail_sel`=5, `pass`=0.
- **Zero-register mismatch:** `ZERO_REG_HARDWIRED`=1 but the model stores reg 0.
  - Response: `fail_count`=4, `first_fail_sel`=0, `pass`=0.
  - With `ZERO_REG_HARDWIRED`=0 on the same model: `pass`=1.
- **Saturation:** `ZERO_REG_HARDWIRED`=0, model returns 32'hFFFFFFFF always.
  - 128 mismatches occur; `fail_count` must saturate at 127 (7 bits), not wrap.
- **Reset mid-test:** assert `reset` for 1 cycle at E40.
  - Next cycle: `busy`=0, `write`=0, `fail_count`=0.
  - A new `start` runs a full 128-cycle test that passes.
- **Start during busy:** pulse `start` at E10 and E70.
  - Both are ignored; `done` still rises after E128.
  - A `start` in DONE clears `done` and `pass` on the next edge and reruns the test.
